conv_window_sched: RTL
======================

Name: conv_window_sched

Overview:
- Frame-level scheduler for the convolution window datapath (line buffers plus the filter-generator mux network).
- Accepts a raster-order pixel stream for one feature map after a `start` pulse and drives the line-buffer shift enable.
- Raises `win_valid` when the KxK window behind the current pixel is complete, and holds it under downstream backpressure.
- Pulses `done` after the last window of the frame is consumed. Sits between the input feature-map fetcher and the MAC array.

Parameters:
- IMG_W, 8, feature-map width in pixels (>= K)
- IMG_H, 8, feature-map height in pixels (>= K)
- K, 3, square kernel size (stride fixed at 1, no padding)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  pixel present on upstream stream
- in_ready  out  1  scheduler accepts pixel this cycle
- out_ready  in  1  downstream (MAC array) accepts current window
- shift_en  out  1  line-buffer/window-register shift strobe
- win_valid  out  1  window registers hold a valid KxK window
- win_row  out  $clog2(IMG_H)  row of window's bottom-right pixel
- win_col  out  $clog2(IMG_W)  column of window's bottom-right pixel
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE; row/col counters=0; win_valid=0, win_row=0, win_col=0, done=0. busy, in_ready and shift_en are 0 through IDLE decode. Reset mid-frame aborts at once: no done pulse, and partial window state is discarded.
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE: `start`=1 -> STREAM, counters cleared. Other inputs are ignored.
- STREAM:
  - in_ready = !win_valid | out_ready (combinational).
  - Accept = in_valid & in_ready. shift_en = accept, same cycle.
  - On accept at (row,col): col increments; at col==IMG_W-1, col wraps to 0 and row increments.
  - Window generation on accept:
    - If row>=K-1 and col>=K-1, the next cycle has win_valid=1, win_row=row, win_col=col.
    - Otherwise win_valid clears if out_ready, else holds.
  - Accepting the pixel at (IMG_H-1, IMG_W-1) -> FLUSH.
- Window hold: win_valid with out_ready=0 holds win_valid, win_row and win_col stable, and in_ready=0. No pixel is lost or shifted.
- Simultaneous consume and produce: out_ready=1 together with an accept that completes a window leaves win_valid=1 with new coordinates (back-to-back windows, 1 per cycle).
- FLUSH: in_ready=0, shift_en=0. When win_valid==0, or win_valid & out_ready, clear win_valid -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=1 in STREAM, FLUSH and DONE.
- Latency: 1 cycle from accepting a window-completing pixel to win_valid.
- Window count per frame: (IMG_H-K+1)*(IMG_W-K+1). With defaults: 36 windows, 64 pixels.
- in_valid while in IDLE, FLUSH or DONE is not accepted.
- start while busy is ignored.
- Counter arithmetic is unsigned. Counters never exceed IMG_W-1 / IMG_H-1.

Test Plan:
- Reset: drive rst=0 for 2 cycles mid-stream -> next cycle state IDLE, win_valid=0, busy=0, in_ready=0, done=0; no done pulse ever appears for the aborted frame.
- Full-rate frame: defaults, in_valid=1 and out_ready=1 continuously after start -> exactly 64 shift_en cycles and 36 win_valid cycles.
  - First window appears the cycle after pixel 18 (row 2, col 2), with win_row=2, win_col=2.
  - Last window has win_row=7, win_col=7.
  - done pulses once, 2 cycles after the last accept.
- Row wrap: at row 2, cols 0–1 produce no window, and col 2 produces one -> win_valid is low for the 2 cycles after the accepts of pixels (3,0) and (3,1).
- Backpressure: hold out_ready=0 when the window (4,5) is valid for 5 cycles with in_valid=1 -> in_ready=0 and shift_en=0 for 5 cycles, and win_row/win_col stay at 4/5. Release -> accept resumes and the next window is (4,6).
- Upstream bubbles: randomly deassert in_valid (50%) with out_ready=1 -> still 36 windows, coordinates in raster order, no duplicates.
- Control corners:
  - start asserted while busy -> no restart; counters continue.
  - Final window stalled in FLUSH for 3 cycles -> done only after the consume.
  - IMG_W=IMG_H=K=3 -> exactly 1 window at (2,2).

Source files
------------

// File: rtl/conv_window_sched.sv
// Frame scheduler for the KxK convolution window datapath: tracks the raster position of the
// incoming pixel stream, strobes the line-buffer shift and presents window coordinates.
module conv_window_sched #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned K     = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic                     i_out_ready,
  output logic                     o_shift_en,
  output logic                     o_win_valid,
  output logic [$clog2(IMG_H)-1:0] o_win_row,
  output logic [$clog2(IMG_W)-1:0] o_win_col,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  localparam logic [RW-1:0] RowLast     = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColLast     = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowFirstWin = RW'(K - 1);
  localparam logic [CW-1:0] ColFirstWin = CW'(K - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  state_e        r_state, w_state_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic          r_win_valid, w_win_valid_nxt;
  logic [RW-1:0] r_win_row, w_win_row_nxt;
  logic [CW-1:0] r_win_col, w_win_col_nxt;
  logic          w_in_ready;
  logic          w_accept;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_row       <= '0;
      r_col       <= '0;
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_win_valid <= w_win_valid_nxt;
      r_win_row   <= w_win_row_nxt;
      r_win_col   <= w_win_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_win_valid_nxt = r_win_valid;
    w_win_row_nxt   = r_win_row;
    w_win_col_nxt   = r_win_col;
    w_in_ready      = 1'b0;
    w_accept        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt     = StStream;
          w_row_nxt       = '0;
          w_col_nxt       = '0;
          w_win_valid_nxt = 1'b0;
        end
      end

      StStream: begin
        // A held window blocks the stream so the window registers never shift under it.
        w_in_ready = !r_win_valid || i_out_ready;
        w_accept   = w_in_ready && i_in_valid;
        if (w_accept) begin
          if (r_row >= RowFirstWin && r_col >= ColFirstWin) begin
            w_win_valid_nxt = 1'b1;
            w_win_row_nxt   = r_row;
            w_win_col_nxt   = r_col;
          end else begin
            w_win_valid_nxt = r_win_valid && !i_out_ready;
          end

          if (r_col == ColLast) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row == RowLast) ? '0 : r_row + RW'(1);
          end else begin
            w_col_nxt = r_col + CW'(1);
          end

          if (r_row == RowLast && r_col == ColLast) begin
            w_state_nxt = StFlush;
          end
        end else if (i_out_ready) begin
          w_win_valid_nxt = 1'b0;
        end
      end

      StFlush: begin
        if (!r_win_valid || i_out_ready) begin
          w_win_valid_nxt = 1'b0;
          w_state_nxt     = StDone;
        end
      end

      StDone: begin
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign o_in_ready  = w_in_ready;
  assign o_shift_en  = w_accept;
  assign o_win_valid = r_win_valid;
  assign o_win_row   = r_win_row;
  assign o_win_col   = r_win_col;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);

endmodule
